// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } pctrl_state_t;

  localparam logic [4:0] REG_X0     = 5'd0;
  localparam int         WAIT_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Enable-driven counter that sticks at all-ones; async clear.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != C_MAX)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer: load-use, EX redirect, dmem wait/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             memRead_ex,
  input  logic             redirect_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready_mem,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             bus_error,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [WAIT_CNT_W-1:0] C_WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  pctrl_state_t          r_state;
  pctrl_state_t          w_next_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_bus_error;
  logic                  w_enter_wait;
  logic                  w_load_use;
  logic                  w_freeze;
  logic                  w_redirect_applied;

  always_comb begin
    w_next_state       = r_state;
    w_freeze           = 1'b0;
    w_redirect_applied = 1'b0;
    pc_stall           = 1'b0;
    if_id_stall        = 1'b0;
    id_ex_stall        = 1'b0;
    ex_mem_stall       = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    mem_wb_flush       = 1'b0;

    w_enter_wait = dmem_req_mem && !dmem_ready_mem;
    w_load_use   = memRead_ex && (rd_ex != REG_X0) &&
                   ((use_rs1_id && (rs1_id == rd_ex)) ||
                    (use_rs2_id && (rs2_id == rd_ex)));

    case (r_state)
      RUN: begin
        w_freeze = w_enter_wait;
        if (w_enter_wait) w_next_state = WAIT;
      end
      WAIT: begin
        // Freeze releases in the ready cycle itself so the pipe advances on that edge.
        w_freeze = !dmem_ready_mem;
        if (dmem_ready_mem)                 w_next_state = RUN;
        else if (r_wait_cnt == C_WAIT_LAST) w_next_state = ERROR;
      end
      ERROR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase

    if (!rst_n) begin
      w_next_state = RUN;
    end else if (w_freeze) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (redirect_ex) begin
      // ID holds a wrong-path instruction, so any load-use hit is moot.
      if_id_flush        = 1'b1;
      id_ex_flush        = 1'b1;
      w_redirect_applied = 1'b1;
    end else if (w_load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == RUN) begin
        r_wait_cnt <= '0;
      end else if ((r_state == WAIT) && !dmem_ready_mem) begin
        r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
      end
      if (w_next_state == ERROR) r_bus_error <= 1'b1;
    end
  end

  assign bus_error = r_bus_error;
  assign state_o   = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (pc_stall),
    .o_count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_redirect_applied),
    .o_count (flush_events)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int             TIMEOUT = 4;
  localparam int             CNT_W   = 4;
  localparam logic [CNT_W-1:0] C_SAT = {CNT_W{1'b1}};

  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;
  localparam logic [3:0] ST_NONE = 4'b0000, ST_LU = 4'b1100, ST_FRZ = 4'b1111;
  localparam logic [2:0] FL_NONE = 3'b000, FL_LU = 3'b010, FL_RD = 3'b110, FL_FRZ = 3'b001;

  typedef struct packed {
    logic [3:0]       st;
    logic [2:0]       fl;
    logic             be;
    logic [1:0]       state;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic use_rs1_id, use_rs2_id, memRead_ex, redirect_ex, dmem_req_mem, dmem_ready_mem;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_flush, bus_error;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] m_sc  = '0;
  logic [CNT_W-1:0] m_fe  = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .memRead_ex(memRead_ex), .redirect_ex(redirect_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready_mem(dmem_ready_mem),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .bus_error(bus_error), .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_hz(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic u1, input logic [4:0] r2, input logic u2);
    memRead_ex = ld; rd_ex = rd; rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
  endtask

  task automatic set_ctl(input logic rdir, input logic req, input logic rdy);
    redirect_ex = rdir; dmem_req_mem = req; dmem_ready_mem = rdy;
  endtask

  // One clock: queue the expectation, compare at the falling edge, advance the counter model.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [2:0] fl,
                     input logic be, input logic [1:0] s);
    exp_t e;
    e = '{st: st, fl: fl, be: be, state: s, sc: m_sc, fe: m_fe};
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_stall"}, 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall}), 32'(e.st));
      check({tag, "_flush"}, 32'({if_id_flush, id_ex_flush, mem_wb_flush}), 32'(e.fl));
      check({tag, "_buserr"}, 32'(bus_error), 32'(e.be));
      check({tag, "_state"}, 32'(state_o), 32'(e.state));
      check({tag, "_stallcnt"}, 32'(stall_cycles), 32'(e.sc));
      check({tag, "_flushcnt"}, 32'(flush_events), 32'(e.fe));
    end
    @(posedge clk);
    #1;
    if (st[3] && (m_sc != C_SAT)) m_sc = m_sc + 1'b1;
    if (fl[2] && (m_fe != C_SAT)) m_fe = m_fe + 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_hz(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    set_ctl(1'b1, 1'b1, 1'b0);
    cyc("in_reset", ST_NONE, FL_NONE, 1'b0, S_RUN);
    rst_n = 1'b1;

    set_hz(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); set_ctl(1'b0, 1'b0, 1'b0);
    cyc("lu_rs1", ST_LU, FL_LU, 1'b0, S_RUN);
    set_hz(1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc("lu_idle", ST_NONE, FL_NONE, 1'b0, S_RUN);
    set_hz(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    cyc("lu_x0", ST_NONE, FL_NONE, 1'b0, S_RUN);
    set_hz(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    cyc("lu_rs2", ST_LU, FL_LU, 1'b0, S_RUN);
    set_hz(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
    cyc("lu_nouse", ST_NONE, FL_NONE, 1'b0, S_RUN);

    set_hz(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0); set_ctl(1'b1, 1'b0, 1'b0);
    cyc("rd_over_lu", ST_NONE, FL_RD, 1'b0, S_RUN);
    set_hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); set_ctl(1'b0, 1'b0, 1'b0);
    cyc("rd_after", ST_NONE, FL_NONE, 1'b0, S_RUN);

    set_ctl(1'b0, 1'b1, 1'b1);
    cyc("mem_same_cyc", ST_NONE, FL_NONE, 1'b0, S_RUN);
    set_ctl(1'b0, 1'b1, 1'b0);
    cyc("mem_enter", ST_FRZ, FL_FRZ, 1'b0, S_RUN);
    cyc("mem_wait1", ST_FRZ, FL_FRZ, 1'b0, S_WAIT);
    set_ctl(1'b1, 1'b1, 1'b0);
    cyc("mem_wait2_rd", ST_FRZ, FL_FRZ, 1'b0, S_WAIT);
    set_ctl(1'b1, 1'b1, 1'b1);
    cyc("mem_ready_rd", ST_NONE, FL_RD, 1'b0, S_WAIT);
    set_ctl(1'b0, 1'b0, 1'b0);
    cyc("mem_back_run", ST_NONE, FL_NONE, 1'b0, S_RUN);

    set_ctl(1'b0, 1'b1, 1'b0);
    cyc("to_enter", ST_FRZ, FL_FRZ, 1'b0, S_RUN);
    for (int i = 0; i < TIMEOUT; i++) cyc("to_wait", ST_FRZ, FL_FRZ, 1'b0, S_WAIT);
    cyc("to_err", ST_FRZ, FL_FRZ, 1'b1, S_ERR);
    set_ctl(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("err_hold", ST_FRZ, FL_FRZ, 1'b1, S_ERR);

    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(state_o), 32'(S_RUN));
    check("async_buserr", 32'(bus_error), 32'd0);
    check("async_stall", 32'(pc_stall), 32'd0);
    check("async_cnt", 32'(stall_cycles), 32'd0);
    m_sc = '0; m_fe = '0;
    cyc("rst_hold", ST_NONE, FL_NONE, 1'b0, S_RUN);
    rst_n = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    cyc("post_rst", ST_NONE, FL_NONE, 1'b0, S_RUN);

    set_hz(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1);
    for (int i = 0; i < 20; i++) cyc("sat_lu", ST_LU, FL_LU, 1'b0, S_RUN);
    set_hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc("sat_end", ST_NONE, FL_NONE, 1'b0, S_RUN);
    check("sat_value", 32'(stall_cycles), 32'd15);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
